// File: rtl/key_debounce.sv
// Six-key push-button debouncer.
// Each key has its own channel: a 2-flop synchronizer, a stability counter and
// a debounced state bit. One-cycle press/release pulses are registered on the
// same edge that updates the debounced state.

// One debounce channel for a single active-low key.
module key_debounce_chan #(
  parameter int unsigned DEBOUNCE_CNT = 1000000,
  parameter int unsigned CNT_W        = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic i_key,
  output logic o_db,
  output logic o_press,
  output logic o_release
);

  // Counter value at which the new level is accepted.
  localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(DEBOUNCE_CNT - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic [CNT_W-1:0] r_cnt;
  logic             r_db;
  logic             r_press;
  logic             r_release;

  logic             w_diff;
  logic             w_fire;
  logic [CNT_W-1:0] w_cnt_nxt;

  // Bring the asynchronous key level into the clk domain; reset reads as released.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= i_key;
      r_sync2 <= r_sync1;
    end
  end

  assign w_diff = r_sync2 ^ r_db;
  assign w_fire = w_diff && (r_cnt == TERMINAL);

  // Count consecutive cycles of disagreement; any agreement or acceptance restarts.
  always_comb begin
    w_cnt_nxt = '0;
    if (w_diff && !w_fire) begin
      w_cnt_nxt = r_cnt + CNT_W'(1);
    end
  end

  // Stability counter; it is bounded by TERMINAL and never wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_nxt;
    end
  end

  // Accept the synchronized level and emit the matching edge pulse on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_db      <= 1'b1;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_press   <= w_fire && !r_sync2;
      r_release <= w_fire &&  r_sync2;
      if (w_fire) begin
        r_db <= r_sync2;
      end
    end
  end

  assign o_db      = r_db;
  assign o_press   = r_press;
  assign o_release = r_release;

endmodule

// Top level: six independent channels, key[6:1] active-low.
module key_debounce #(
  parameter int unsigned DEBOUNCE_CNT = 1000000,
  parameter int unsigned CNT_W        = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:1] key,
  output logic [6:1] key_db,
  output logic [6:1] key_press,
  output logic [6:1] key_release
);

  logic [6:1] w_db;
  logic [6:1] w_press;
  logic [6:1] w_release;

  for (genvar g = 1; g <= 6; g++) begin : g_ch
    key_debounce_chan #(
      .DEBOUNCE_CNT (DEBOUNCE_CNT),
      .CNT_W        (CNT_W)
    ) u_chan (
      .clk       (clk),
      .rst       (rst),
      .i_key     (key[g]),
      .o_db      (w_db[g]),
      .o_press   (w_press[g]),
      .o_release (w_release[g])
    );
  end

  assign key_db      = w_db;
  assign key_press   = w_press;
  assign key_release = w_release;

endmodule
